// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_queue
// Description : Fetch stage between the PC stage and decode. Each cycle it
//               decides whether the offered PC can be issued to the
//               synchronous instruction memory (1-cycle read latency). It
//               captures the returned instruction together with its PC in a
//               small FIFO and presents the FIFO head to decode with a
//               valid/ready handshake. A taken branch (flush) discards all
//               buffered and in-flight fetches. Halt stops new issues while
//               the queue keeps draining.
// Ports       :
//   CLK        in   1     clock, all state on posedge
//   Init_n     in   1     asynchronous active-low reset
//   pc_in      in   W     PC offered by the PC stage
//   pc_valid   in   1     pc_in valid this cycle
//   fetch_rdy  out  1     fetch offered this cycle is accepted
//   flush      in   1     taken branch: drop queue and in-flight read
//   Halt       in   1     block new issues, queue still drains
//   imem_addr  out  W     instruction memory address (= pc_in)
//   imem_rd    out  1     instruction memory read enable
//   imem_data  in   IW    read data, valid the cycle after imem_rd
//   id_instr   out  IW    instruction at FIFO head (0 when empty)
//   id_pc      out  W     PC of FIFO head (0 when empty)
//   id_valid   out  1     head entry valid
//   id_ready   in   1     decode consumes head on id_valid & id_ready
//   q_count    out  CW    occupied entries, 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_queue #(
  parameter int W     = 16,
  parameter int IW    = 9,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     Init_n,
  input  logic [W-1:0]             pc_in,
  input  logic                     pc_valid,
  output logic                     fetch_rdy,
  input  logic                     flush,
  input  logic                     Halt,
  output logic [W-1:0]             imem_addr,
  output logic                     imem_rd,
  input  logic [IW-1:0]            imem_data,
  output logic [IW-1:0]            id_instr,
  output logic [W-1:0]             id_pc,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // FIFO storage; contents need no reset because id_valid gates the outputs.
  logic [IW-1:0] instr_mem [DEPTH];
  logic [W-1:0]  pc_mem    [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          inflight;
  logic [W-1:0]  pend_pc;

  logic [CW:0]   occupancy;
  logic          issue;
  logic          push;
  logic          pop;

  // ---------------------------------------------------------------------------
  // Credit: every in-flight read owns a reserved slot, so a capture can never
  // land in a full FIFO. Evaluated on the pre-pop count, so a full FIFO that is
  // popped this cycle still refuses the fetch. Init_n gates it so that no
  // fetch is accepted while reset is held.
  // ---------------------------------------------------------------------------
  assign occupancy = {1'b0, count} + (CW+1)'(inflight);
  assign fetch_rdy = Init_n & ~flush & ~Halt & (occupancy < (CW+1)'(DEPTH));

  assign issue     = pc_valid & fetch_rdy;
  assign imem_rd   = issue;
  assign imem_addr = pc_in;

  // Capture and pop are both suppressed by flush; flush wins over everything.
  assign push      = inflight & ~flush;
  assign pop       = id_valid & id_ready & ~flush;

  assign id_valid  = (count != '0);
  assign q_count   = count;
  assign id_instr  = id_valid ? instr_mem[rd_ptr] : '0;
  assign id_pc     = id_valid ? pc_mem[rd_ptr]    : '0;

  // ---------------------------------------------------------------------------
  // Control state: pointers, occupancy and the in-flight tracker.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge Init_n) begin
    if (!Init_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      inflight <= 1'b0;
      pend_pc  <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      inflight <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // A new issue in the capture cycle keeps the tracker set for the next
      // read, which is what gives one instruction per cycle back to back.
      inflight <= issue;
      if (issue) begin
        pend_pc <= pc_in;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO write port. Only ever written while reset is released and no flush
  // is present (push already excludes flush); the returned data is paired
  // with the PC latched at issue time.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (push && Init_n) begin
      instr_mem[wr_ptr] <= imem_data;
      pc_mem[wr_ptr]    <= pend_pc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_queue
// Description : Self-checking bench for instr_fetch_queue. A behavioural
//               queue model predicts credit, issue and delivery; a monitor on
//               the falling edge compares the DUT against it every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_queue;

  localparam int W     = 16;
  localparam int IW    = 9;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic           CLK = 1'b0;
  logic           Init_n = 1'b0;
  logic [W-1:0]   pc_in = '0;
  logic           pc_valid = 1'b0;
  logic           fetch_rdy;
  logic           flush = 1'b0;
  logic           Halt = 1'b0;
  logic [W-1:0]   imem_addr;
  logic           imem_rd;
  logic [IW-1:0]  imem_data = '0;
  logic [IW-1:0]  id_instr;
  logic [W-1:0]   id_pc;
  logic           id_valid;
  logic           id_ready = 1'b0;
  logic [CW-1:0]  q_count;

  instr_fetch_queue #(.W(W), .IW(IW), .DEPTH(DEPTH)) dut (
    .CLK       (CLK),
    .Init_n    (Init_n),
    .pc_in     (pc_in),
    .pc_valid  (pc_valid),
    .fetch_rdy (fetch_rdy),
    .flush     (flush),
    .Halt      (Halt),
    .imem_addr (imem_addr),
    .imem_rd   (imem_rd),
    .imem_data (imem_data),
    .id_instr  (id_instr),
    .id_pc     (id_pc),
    .id_valid  (id_valid),
    .id_ready  (id_ready),
    .q_count   (q_count)
  );

  always #5 CLK = ~CLK;

  // Instruction ROM content: ROM[a] = a + 0x10, truncated to IW bits.
  function automatic logic [IW-1:0] rom(input logic [W-1:0] a);
    logic [W-1:0] s;
    s = a + 16'h0010;
    return s[IW-1:0];
  endfunction

  // Synchronous instruction memory, one-cycle read latency.
  always @(posedge CLK) begin
    if (imem_rd) imem_data <= rom(imem_addr);
  end

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: an ordered list of fetched-but-undelivered instructions
  // plus at most one outstanding memory read.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [W-1:0]  pc;
    logic [IW-1:0] ins;
  } ent_t;

  ent_t         mq[$];
  bit           m_inflight = 1'b0;
  ent_t         m_pend;
  int           m_issued = 0;
  int           m_delivered = 0;

  // Monitor: inputs are stable between the driver's update (posedge+1) and the
  // next posedge, so the falling edge sees the settled cycle.
  always @(negedge CLK) begin
    logic exp_rdy;
    if (!Init_n) begin
      mq.delete();
      m_inflight = 1'b0;
    end
    exp_rdy = Init_n && !flush && !Halt && ((mq.size() + int'(m_inflight)) < DEPTH);
    chk("fetch_rdy", 32'(fetch_rdy), 32'(exp_rdy));
    chk("imem_rd", 32'(imem_rd), 32'(pc_valid & exp_rdy));
    if (pc_valid && exp_rdy) chk("imem_addr", 32'(imem_addr), 32'(pc_in));
    chk("q_count", 32'(q_count), 32'(mq.size()));
    chk("id_valid", 32'(id_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("id_pc", 32'(id_pc), 32'(mq[0].pc));
      chk("id_instr", 32'(id_instr), 32'(mq[0].ins));
    end
    // Advance the model to the state after the coming posedge.
    if (Init_n) begin
      if (flush) begin
        mq.delete();
        m_inflight = 1'b0;
      end else begin
        if (mq.size() != 0 && id_ready) begin
          void'(mq.pop_front());
          m_delivered++;
        end
        if (m_inflight) mq.push_back(m_pend);
        m_inflight = pc_valid && exp_rdy;
        if (m_inflight) begin
          m_pend = '{pc: pc_in, ins: rom(pc_in)};
          m_issued++;
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int start;
    int cyc;

    // Reset state, checked before any clock edge.
    #1;
    chk("rst_id_valid", 32'(id_valid), 0);
    chk("rst_id_instr", 32'(id_instr), 0);
    chk("rst_id_pc", 32'(id_pc), 0);
    chk("rst_q_count", 32'(q_count), 0);
    chk("rst_fetch_rdy", 32'(fetch_rdy), 0);
    chk("rst_imem_rd", 32'(imem_rd), 0);
    step();
    Init_n = 1'b1;

    // 1: straight-line fetch of PCs 0..3 with decode always ready.
    id_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pc_valid = 1'b1;
      pc_in    = 16'(i);
      step();
    end
    pc_valid = 1'b0;
    repeat (4) step();

    // 2: decode stalled, queue fills, then a single pop frees one credit.
    id_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pc_valid = 1'b1;
      pc_in    = 16'h0100 + 16'(i);
      step();
    end
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pc_in = 16'h0200 + 16'(i);
      step();
    end
    pc_valid = 1'b0;
    id_ready = 1'b1;
    repeat (8) step();

    // 3: three queued plus one in flight, then a one-cycle flush to PC 5.
    id_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pc_valid = 1'b1;
      pc_in    = 16'h0300 + 16'(i);
      step();
    end
    flush = 1'b1;
    pc_in = 16'd5;
    id_ready = 1'b1;
    step();
    flush = 1'b0;
    id_ready = 1'b0;
    step();
    pc_valid = 1'b0;
    repeat (3) step();
    id_ready = 1'b1;
    repeat (3) step();

    // 4: Halt with two queued plus one in flight; everything drains.
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pc_valid = 1'b1;
      pc_in    = 16'h0400 + 16'(i);
      step();
    end
    Halt     = 1'b1;
    id_ready = 1'b1;
    repeat (6) step();
    Halt     = 1'b0;
    pc_in    = 16'h0410;
    step();
    pc_valid = 1'b0;
    repeat (4) step();

    // 5: asynchronous reset mid-operation with three queued.
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pc_valid = 1'b1;
      pc_in    = 16'h0500 + 16'(i);
      step();
    end
    pc_valid = 1'b0;
    repeat (2) step();
    chk("pre_async_q_count", 32'(q_count), 3);
    pc_valid = 1'b1;
    #1 Init_n = 1'b0;
    #1;
    chk("async_id_valid", 32'(id_valid), 0);
    chk("async_q_count", 32'(q_count), 0);
    chk("async_fetch_rdy", 32'(fetch_rdy), 0);
    chk("async_imem_rd", 32'(imem_rd), 0);
    chk("async_id_instr", 32'(id_instr), 0);
    chk("async_id_pc", 32'(id_pc), 0);
    pc_valid = 1'b0;
    step();
    Init_n   = 1'b1;
    id_ready = 1'b1;
    repeat (4) step();

    // 6: randomized traffic until 200 more PCs have been issued.
    start = m_issued;
    cyc   = 0;
    while (m_issued < start + 200 && cyc < 4000) begin
      pc_valid = ($urandom_range(0, 3) != 0);
      pc_in    = 16'($urandom);
      id_ready = ($urandom_range(0, 1) == 1);
      flush    = ($urandom_range(0, 19) == 0);
      Halt     = ($urandom_range(0, 9) == 0);
      step();
      cyc++;
    end
    chk("random_issue_budget", 32'(m_issued >= start + 200), 1);
    flush    = 1'b0;
    Halt     = 1'b0;
    pc_valid = 1'b0;
    id_ready = 1'b1;
    repeat (10) step();
    chk("final_q_count", 32'(q_count), 0);
    chk("final_id_valid", 32'(id_valid), 0);
    chk("delivered_some", 32'(m_delivered > 100), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
